// File: rtl/tile_game_ctrl.sv
// Sliding-tile board controller: one row/column is slid and merged per cycle,
// tiles are placed by an LFSR-seeded linear scan, and win/lose is evaluated after each move.
module tile_game_ctrl #(
  parameter int          N         = 4,
  parameter int          TW        = 12,
  parameter int          SCORE_W   = 20,
  parameter int          WIN_VALUE = 2048,
  parameter int          WIN_MODE  = 0,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  new_game,
  input  logic                  dir_valid,
  input  logic [3:0]            dir,
  output logic                  dir_ready,
  input  logic                  load_en,
  input  logic [N*N*TW-1:0]     load_board,
  output logic [N*N*TW-1:0]     board,
  output logic [SCORE_W-1:0]    score,
  output logic [1:0]            game_state,
  output logic                  busy,
  output logic                  move_done,
  output logic                  move_nochange
);

  // state   | meaning
  // CLEAR   | zero board and score
  // SPAWN1  | place first opening tile
  // SPAWN2  | place second opening tile, then start play
  // IDLE    | wait for move / load / new game
  // MOVE    | slide and merge one line per cycle
  // COMPARE | decide whether the move changed anything
  // SPAWN   | place one tile after a changing move
  // CHECK   | win / lose evaluation, move_done pulse
  // OVER    | game finished, only load or new game accepted
  localparam logic [3:0] S_CLEAR   = 4'd0;
  localparam logic [3:0] S_SPAWN1  = 4'd1;
  localparam logic [3:0] S_SPAWN2  = 4'd2;
  localparam logic [3:0] S_IDLE    = 4'd3;
  localparam logic [3:0] S_MOVE    = 4'd4;
  localparam logic [3:0] S_COMPARE = 4'd5;
  localparam logic [3:0] S_SPAWN   = 4'd6;
  localparam logic [3:0] S_CHECK   = 4'd7;
  localparam logic [3:0] S_OVER    = 4'd8;

  localparam int NC    = N * N;
  localparam int IW    = $clog2(NC);
  localparam int LW    = $clog2(N);
  localparam int SUM_W = TW + 3;
  localparam int SSW   = ((SCORE_W > SUM_W) ? SCORE_W : SUM_W) + 1;

  localparam logic [TW-1:0]      TOP  = {1'b1, {(TW-1){1'b0}}};
  localparam logic [TW-1:0]      WINV = TW'(WIN_VALUE);
  localparam logic [SCORE_W-1:0] SMAX = '1;

  logic [3:0]         state;
  logic [TW-1:0]      cell_q [NC];
  logic [15:0]        lfsr;
  logic [1:0]         mcode;
  logic [LW-1:0]      line_q;
  logic               changed;
  logic [IW-1:0]      scan_idx;
  logic [IW-1:0]      scan_cnt;

  logic [IW-1:0]      lidx     [N];
  logic [TW-1:0]      line_in  [N];
  logic [TW-1:0]      line_out [N];
  logic [TW-1:0]      wk       [N];
  logic [SUM_W-1:0]   line_sum;
  logic               line_diff;
  logic [SSW-1:0]     score_sum;
  logic [SCORE_W-1:0] score_next;

  logic               lfsr_fb;
  logic [IW-1:0]      start_idx;
  logic [IW-1:0]      cur_idx;
  logic [IW-1:0]      next_idx;
  logic               scan_last;
  logic               cur_empty;
  logic [TW-1:0]      spawn_val;

  logic               any_win;
  logic               any_empty;
  logic               any_pair;
  logic               dir_onehot;
  logic               move_ok;

  assign lfsr_fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign start_idx  = IW'(lfsr % 16'(NC));
  assign cur_idx    = (scan_cnt == '0) ? start_idx : scan_idx;
  assign next_idx   = (cur_idx == IW'(NC-1)) ? '0 : cur_idx + IW'(1);
  assign scan_last  = (scan_cnt == IW'(NC-1));
  assign cur_empty  = (cell_q[cur_idx] == '0);
  assign spawn_val  = (lfsr[15:12] == 4'd0) ? TW'(4) : TW'(2);

  assign dir_onehot = (dir == 4'b0001) || (dir == 4'b0010) ||
                      (dir == 4'b0100) || (dir == 4'b1000);
  assign dir_ready  = !rst && (state == S_IDLE) && !load_en && !new_game;
  assign move_ok    = dir_valid && dir_ready && dir_onehot;
  assign busy       = rst || ((state != S_IDLE) && (state != S_OVER));

  for (genvar g = 0; g < NC; g++) begin : g_board
    assign board[g*TW +: TW] = cell_q[g];
  end

  // Each line is gathered so that index 0 is the edge tiles slide toward.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      case (mcode)
        2'd0:    lidx[j] = IW'(j * N + int'(line_q));
        2'd1:    lidx[j] = IW'((N - 1 - j) * N + int'(line_q));
        2'd3:    lidx[j] = IW'(int'(line_q) * N + (N - 1 - j));
        default: lidx[j] = IW'(int'(line_q) * N + j);
      endcase
      line_in[j] = cell_q[lidx[j]];
      wk[j]      = line_in[j];
    end
    for (int p = 0; p < N; p++) begin
      for (int j = 0; j < N - 1; j++) begin
        if (wk[j] == '0) begin
          wk[j]   = wk[j+1];
          wk[j+1] = '0;
        end
      end
    end
    // Ascending scan gives the leading edge merge priority; the zeroed partner
    // prevents a freshly merged tile from merging again.
    line_sum = '0;
    for (int j = 0; j < N - 1; j++) begin
      if ((wk[j] != '0) && (wk[j] == wk[j+1]) && (wk[j] != TOP)) begin
        wk[j]    = wk[j] << 1;
        wk[j+1]  = '0;
        line_sum = line_sum + SUM_W'(wk[j]);
      end
    end
    for (int p = 0; p < N; p++) begin
      for (int j = 0; j < N - 1; j++) begin
        if (wk[j] == '0) begin
          wk[j]   = wk[j+1];
          wk[j+1] = '0;
        end
      end
    end
    line_diff = 1'b0;
    for (int j = 0; j < N; j++) begin
      line_out[j] = wk[j];
      if (wk[j] != line_in[j]) line_diff = 1'b1;
    end
  end

  always_comb begin
    score_sum  = SSW'(score) + SSW'(line_sum);
    score_next = (score_sum > SSW'(SMAX)) ? SMAX : score_sum[SCORE_W-1:0];
  end

  always_comb begin
    any_win   = 1'b0;
    any_empty = 1'b0;
    any_pair  = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (cell_q[i] >= WINV) any_win = 1'b1;
      if (cell_q[i] == '0)   any_empty = 1'b1;
    end
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N - 1; c++) begin
        if (cell_q[r*N+c] == cell_q[r*N+c+1]) any_pair = 1'b1;
      end
    end
    for (int r = 0; r < N - 1; r++) begin
      for (int c = 0; c < N; c++) begin
        if (cell_q[r*N+c] == cell_q[(r+1)*N+c]) any_pair = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_CLEAR;
      score         <= '0;
      game_state    <= 2'b00;
      lfsr          <= SEED;
      mcode         <= 2'd2;
      line_q        <= '0;
      changed       <= 1'b0;
      scan_idx      <= '0;
      scan_cnt      <= '0;
      move_done     <= 1'b0;
      move_nochange <= 1'b0;
      for (int i = 0; i < NC; i++) cell_q[i] <= '0;
    end else begin
      lfsr          <= {lfsr[14:0], lfsr_fb};
      move_done     <= 1'b0;
      move_nochange <= 1'b0;
      case (state)
        S_CLEAR: begin
          for (int i = 0; i < NC; i++) cell_q[i] <= '0;
          score      <= '0;
          game_state <= 2'b00;
          scan_cnt   <= '0;
          state      <= S_SPAWN1;
        end
        S_SPAWN1, S_SPAWN2, S_SPAWN: begin
          if (cur_empty) cell_q[cur_idx] <= spawn_val;
          if (cur_empty || scan_last) begin
            scan_cnt <= '0;
            if (state == S_SPAWN1) begin
              state <= S_SPAWN2;
            end else if (state == S_SPAWN2) begin
              game_state <= 2'b01;
              state      <= S_IDLE;
            end else begin
              state <= S_CHECK;
            end
          end else begin
            scan_cnt <= scan_cnt + IW'(1);
            scan_idx <= next_idx;
          end
        end
        S_IDLE, S_OVER: begin
          if (new_game) begin
            state <= S_CLEAR;
          end else if (load_en) begin
            for (int i = 0; i < NC; i++) cell_q[i] <= load_board[i*TW +: TW];
            game_state <= 2'b01;
            state      <= S_CHECK;
          end else if ((state == S_IDLE) && move_ok) begin
            mcode   <= dir[0] ? 2'd0 : dir[1] ? 2'd1 : dir[2] ? 2'd2 : 2'd3;
            line_q  <= '0;
            changed <= 1'b0;
            state   <= S_MOVE;
          end
        end
        S_MOVE: begin
          for (int j = 0; j < N; j++) cell_q[lidx[j]] <= line_out[j];
          changed <= changed | line_diff;
          score   <= score_next;
          line_q  <= line_q + LW'(1);
          if (line_q == LW'(N-1)) state <= S_COMPARE;
        end
        S_COMPARE: begin
          if (!changed) begin
            move_done     <= 1'b1;
            move_nochange <= 1'b1;
            state         <= S_IDLE;
          end else begin
            state <= S_SPAWN;
          end
        end
        S_CHECK: begin
          move_done <= 1'b1;
          if (any_win && (game_state == 2'b01)) begin
            game_state <= 2'b10;
            state      <= (WIN_MODE == 0) ? S_OVER : S_IDLE;
          end else if (!any_empty && !any_pair) begin
            game_state <= 2'b11;
            state      <= S_OVER;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule
